// File: rtl/ccu_pkg.sv
// Shared definitions for the crossing control unit: multiplier codes,
// timer state encoding and default timing constants.
package ccu_pkg;

    localparam logic [1:0] MULT_GUARD = 2'd0;
    localparam logic [1:0] MULT_GREEN = 2'd1;
    localparam logic [1:0] MULT_RED   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIRED = 2'd2
    } timer_state_t;

    localparam int DEF_TICK_DIV    = 1000;
    localparam int DEF_BASE_TICKS  = 5;
    localparam int DEF_GUARD_TICKS = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width that holds the longest phase (multiplier 3) or the guard phase.
    function automatic int ticks_width(input int base_ticks, input int guard_ticks);
        return $clog2(max_int(3 * base_ticks, guard_ticks) + 1);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a base tick: counts 0..TICK_DIV-1 while enabled and
// flags the edge on which the count wraps.
module tick_prescaler
    import ccu_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tick
);

    localparam int             PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_count;
    logic          w_wrap;

    assign w_wrap = (r_count == LAST);

    // A clear on the wrap edge swallows that tick.
    assign o_tick = i_enable && w_wrap && !i_clear;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= w_wrap ? '0 : r_count + PW'(1);
        end
    end

endmodule

// File: rtl/crossing_timer.sv
// Phase timer for the pedestrian crossing controller: loads a phase length on
// tr, counts it down in base ticks and pulses proceed when it elapses.
module crossing_timer
    import ccu_pkg::*;
#(
    parameter  int TICK_DIV    = DEF_TICK_DIV,
    parameter  int BASE_TICKS  = DEF_BASE_TICKS,
    parameter  int GUARD_TICKS = DEF_GUARD_TICKS,
    localparam int CW          = ticks_width(BASE_TICKS, GUARD_TICKS)
) (
    input  logic          i_clk,
    input  logic          i_reset,      // asynchronous, active low
    input  logic          i_tr,
    input  logic [1:0]    i_multiplier,
    input  logic          i_hold,
    output logic          o_proceed,
    output logic          o_busy,
    output logic [CW-1:0] o_ticks_left
);

    timer_state_t  r_state;
    logic [CW-1:0] r_ticks_left;
    logic          r_proceed;
    logic          r_busy;

    logic [CW-1:0] w_load;
    logic          w_enable;
    logic          w_tick;

    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_load = CW'(GUARD_TICKS);
        if (i_multiplier != MULT_GUARD) begin
            w_load = CW'(i_multiplier) * CW'(BASE_TICKS);
        end
    end

    // Hold freezes only the running phase; IDLE and FIRED ignore it.
    assign w_enable = (r_state == RUN) && !i_hold;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (i_tr),
        .i_enable (w_enable),
        .o_tick   (w_tick)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= IDLE;
            r_ticks_left <= '0;
            r_proceed    <= 1'b0;
            r_busy       <= 1'b0;
        end else if (i_tr) begin
            r_state      <= RUN;
            r_ticks_left <= w_load;
            r_proceed    <= 1'b0;
            r_busy       <= 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    r_proceed <= 1'b0;
                    if (w_tick) begin
                        if (r_ticks_left <= CW'(1)) begin
                            r_state      <= FIRED;
                            r_ticks_left <= '0;
                            r_proceed    <= 1'b1;
                            r_busy       <= 1'b0;
                        end else begin
                            r_ticks_left <= r_ticks_left - CW'(1);
                        end
                    end
                end
                FIRED: begin
                    r_state   <= IDLE;
                    r_proceed <= 1'b0;
                end
                default: begin
                    r_state      <= IDLE;
                    r_ticks_left <= '0;
                    r_proceed    <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign o_proceed    = r_proceed;
    assign o_busy       = r_busy;
    assign o_ticks_left = r_ticks_left;

endmodule

// File: tb/tb_crossing_timer.sv
// Scoreboard bench for crossing_timer with TICK_DIV=4, BASE_TICKS=3, GUARD_TICKS=1.
module tb_crossing_timer;
    import ccu_pkg::*;

    localparam int TICK_DIV = 4;
    localparam int BASE     = 3;
    localparam int GUARD    = 1;
    localparam int CW       = 4;

    typedef enum int {GREEN = 0, ORANGE = 1, RED = 2} ctrl_state_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          tr = 1'b0;
    logic [1:0]    mult = 2'd0;
    logic          hold = 1'b0;
    logic          proceed;
    logic          busy;
    logic [CW-1:0] ticks_left;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   exp_q[$];
    logic prev_proceed = 1'b0;

    crossing_timer #(
        .TICK_DIV    (TICK_DIV),
        .BASE_TICKS  (BASE),
        .GUARD_TICKS (GUARD)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset_n),
        .i_tr         (tr),
        .i_multiplier (mult),
        .i_hold       (hold),
        .o_proceed    (proceed),
        .o_busy       (busy),
        .o_ticks_left (ticks_left)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Phase length in clk cycles: multiplier 0 is the guard phase.
    function automatic int phase_len(input logic [1:0] m);
        return ((m == 2'd0) ? GUARD : int'(m) * BASE) * TICK_DIV;
    endfunction

    function automatic logic [1:0] ctrl_mult(input ctrl_state_t s);
        case (s)
            GREEN:   return MULT_GREEN;
            ORANGE:  return MULT_GUARD;
            default: return MULT_RED;
        endcase
    endfunction

    function automatic ctrl_state_t ctrl_next(input ctrl_state_t s);
        case (s)
            GREEN:   return ORANGE;
            ORANGE:  return RED;
            default: return GREEN;
        endcase
    endfunction

    // Monitor: every proceed pulse must match the oldest expected pulse cycle.
    always @(negedge clk) begin
        if (proceed === 1'b1) begin
            check("busy_low_with_proceed", {31'd0, busy}, 32'd0);
            check("proceed_not_back_to_back", {31'd0, prev_proceed}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_proceed: pulse at cycle %0d, expected none", cyc);
            end else begin
                check("proceed_cycle", cyc, exp_q.pop_front());
            end
        end
        prev_proceed = proceed;
    end

    // Called at a negedge: tr is sampled on the next posedge (E0); returns at
    // the negedge one cycle after E0 with tr released.
    task automatic start_phase(input logic [1:0] m, input bit expect_pulse, input int hold_edges);
        tr   = 1'b1;
        mult = m;
        if (expect_pulse) exp_q.push_back(cyc + 1 + phase_len(m) + hold_edges);
        @(negedge clk);
        tr = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((busy !== 1'b0 || proceed !== 1'b0 || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, n < budget}, 32'd1);
    endtask

    initial begin
        logic [1:0]  seq [3] = '{2'd3, 2'd0, 2'd2};
        ctrl_state_t ctrl;
        int          advances;
        int          n;

        // Reset and quiet idle period
        repeat (3) @(negedge clk);
        check("reset_proceed", {31'd0, proceed}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_ticks_left", {28'd0, ticks_left}, 32'd0);
        reset_n = 1'b1;
        repeat (50) begin
            @(negedge clk);
            check("idle_outputs", {26'd0, proceed, busy, ticks_left}, 32'd0);
        end

        // multiplier 1: 12 cycles, ticks_left 3/2/1 at cycles 1/5/9
        @(negedge clk);
        start_phase(MULT_GREEN, 1'b1, 0);
        check("m1_ticks_c1", {28'd0, ticks_left}, 32'd3);
        check("m1_busy_c1", {31'd0, busy}, 32'd1);
        repeat (4) @(negedge clk);
        check("m1_ticks_c5", {28'd0, ticks_left}, 32'd2);
        repeat (4) @(negedge clk);
        check("m1_ticks_c9", {28'd0, ticks_left}, 32'd1);
        wait_idle("m1_done", 40);
        check("m1_ticks_after", {28'd0, ticks_left}, 32'd0);

        // multipliers 3, 0, 2: 36, 4, 24 cycles
        foreach (seq[i]) begin
            @(negedge clk);
            start_phase(seq[i], 1'b1, 0);
            check("phase_ticks_loaded", {28'd0, ticks_left},
                  (seq[i] == 2'd0) ? 32'd1 : 32'(int'(seq[i]) * BASE));
            wait_idle("phase_done", 200);
        end

        // hold for 5 edges from cycle 6 of a multiplier-1 phase: pulse after E0+17
        @(negedge clk);
        start_phase(MULT_GREEN, 1'b1, 5);
        repeat (5) @(negedge clk);
        hold = 1'b1;
        repeat (5) @(negedge clk);
        check("hold_ticks_frozen", {28'd0, ticks_left}, 32'd2);
        hold = 1'b0;
        wait_idle("hold_done", 60);

        // tr while hold is high: guard phase frozen for 3 edges
        @(negedge clk);
        hold = 1'b1;
        start_phase(MULT_GUARD, 1'b1, 3);
        repeat (3) @(negedge clk);
        check("tr_in_hold_ticks", {28'd0, ticks_left}, 32'd1);
        check("tr_in_hold_busy", {31'd0, busy}, 32'd1);
        hold = 1'b0;
        wait_idle("tr_in_hold_done", 40);

        // restart at cycle 6 with multiplier 3: no pulse at E12, pulse 36 after restart
        @(negedge clk);
        start_phase(MULT_GREEN, 1'b0, 0);
        repeat (5) @(negedge clk);
        start_phase(MULT_RED, 1'b1, 0);
        check("restart_ticks", {28'd0, ticks_left}, 32'd9);
        wait_idle("restart_done", 200);

        // reset at cycle 7 of a phase
        @(negedge clk);
        start_phase(MULT_GREEN, 1'b0, 0);
        repeat (6) @(negedge clk);
        check("busy_before_reset", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("midreset_outputs", {26'd0, proceed, busy, ticks_left}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_reset_idle", {26'd0, proceed, busy, ticks_left}, 32'd0);

        // closed loop with a minimal crossing controller: green, orange, red
        @(negedge clk);
        ctrl = GREEN;
        advances = 0;
        n = 0;
        start_phase(ctrl_mult(ctrl), 1'b1, 0);
        while (advances < 3 && n < 300) begin
            if (proceed === 1'b1) begin
                advances++;
                ctrl = ctrl_next(ctrl);
                if (advances < 3) begin
                    tr   = 1'b1;
                    mult = ctrl_mult(ctrl);
                    exp_q.push_back(cyc + 1 + phase_len(mult));
                end
            end
            @(negedge clk);
            tr = 1'b0;
            n++;
        end
        wait_idle("loop_done", 60);
        check("loop_advances", advances, 32'd3);
        check("loop_final_state", int'(ctrl), int'(GREEN));
        check("queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
